// File: rtl/neo_bus_pkg.sv
// neo_bus_pkg
// Shared definitions for the 68000 bus-cycle controller:
//   region_t  - address-space classification of a CPU access
//   state_t   - bus-cycle sequencer states
//   OPEN_BUS  - value returned to the CPU when nothing drives the bus
//   region_of - decode of byte-address bits [23:20] into a region
package neo_bus_pkg;

  typedef enum logic [1:0] {
    RGN_MEM,
    RGN_IO,
    RGN_UNMAPPED
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_IO_WAIT,
    ST_ACK
  } state_t;

  localparam logic [15:0] OPEN_BUS = 16'hFFFF;

  // 0x0-0x2 and 0xC-0xD are SDRAM-backed, 0xE-0xF float, the rest is I/O.
  function automatic region_t region_of(input logic [3:0] nib);
    region_t r;
    case (nib)
      4'h0, 4'h1, 4'h2, 4'hC, 4'hD: r = RGN_MEM;
      4'hE, 4'hF:                   r = RGN_UNMAPPED;
      default:                      r = RGN_IO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl
// Watches the 68000 strobes, classifies each access by address region and
// sequences it to the memory port or the I/O space, generating nDTACK and
// returning read data. All outputs are registered.
//
// Ports:
//   CLK_68KCLK, nRESET           clock, asynchronous active-low reset
//   M68K_ADDR[23:1], nAS, nUDS,  CPU address and strobes
//   nLDS, M68K_RW, M68K_DATAOUT  CPU direction and write data
//   nDTACK, CPU_DATAIN           acknowledge and read data to the CPU
//   MEM_REQ/ADDR/WE/BE/WDATA     level-held memory request and its payload
//   MEM_ACK, MEM_RDATA           one-cycle memory completion and read data
//   IO_SEL, IO_RDATA             I/O access in progress, I/O read data
//   TIMEOUT_ERR                  one-cycle pulse on memory timeout
module m68k_bus_ctrl
  import neo_bus_pkg::*;
#(
  parameter int IO_WAIT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK_68KCLK,
  input  logic        nRESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_DATAOUT,
  output logic        nDTACK,
  output logic [15:0] CPU_DATAIN,
  output logic        MEM_REQ,
  output logic [22:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [1:0]  MEM_BE,
  output logic [15:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA,
  output logic        IO_SEL,
  input  logic [15:0] IO_RDATA,
  output logic        TIMEOUT_ERR
);

  localparam int CW = 16;
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] IOW_CNT = CW'(IO_WAIT);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dtack_n;
  logic [15:0]   r_cpu_datain;
  logic          r_mem_req;
  logic [22:0]   r_mem_addr;
  logic          r_mem_we;
  logic [1:0]    r_mem_be;
  logic [15:0]   r_mem_wdata;
  logic          r_io_sel;
  logic          r_timeout_err;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_dtack_n_next;
  logic [15:0]   w_cpu_datain_next;
  logic          w_mem_req_next;
  logic [22:0]   w_mem_addr_next;
  logic          w_mem_we_next;
  logic [1:0]    w_mem_be_next;
  logic [15:0]   w_mem_wdata_next;
  logic          w_io_sel_next;
  logic          w_timeout_err_next;
  logic          w_start;

  assign w_start = !nAS && (!nUDS || !nLDS);

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_dtack_n     <= 1'b1;
      r_cpu_datain  <= OPEN_BUS;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_be      <= 2'b00;
      r_mem_wdata   <= '0;
      r_io_sel      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_dtack_n     <= w_dtack_n_next;
      r_cpu_datain  <= w_cpu_datain_next;
      r_mem_req     <= w_mem_req_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_we      <= w_mem_we_next;
      r_mem_be      <= w_mem_be_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_io_sel      <= w_io_sel_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_cpu_datain_next  = r_cpu_datain;
    w_mem_req_next     = r_mem_req;
    w_mem_addr_next    = r_mem_addr;
    w_mem_we_next      = r_mem_we;
    w_mem_be_next      = r_mem_be;
    w_mem_wdata_next   = r_mem_wdata;
    w_io_sel_next      = r_io_sel;
    w_timeout_err_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_mem_addr_next  = M68K_ADDR;
          w_mem_we_next    = ~M68K_RW;
          w_mem_be_next    = {~nUDS, ~nLDS};
          w_mem_wdata_next = M68K_DATAOUT;
          case (region_of(M68K_ADDR[23:20]))
            RGN_MEM: begin
              w_mem_req_next = 1'b1;
              // Starting at 1 makes the count equal the number of edges
              // since the start edge, so expiry lands exactly on N+TIMEOUT.
              w_cnt_next     = CW'(1);
              w_state_next   = ST_MEM_WAIT;
            end
            RGN_IO: begin
              w_io_sel_next = 1'b1;
              w_cnt_next    = IOW_CNT;
              w_state_next  = ST_IO_WAIT;
            end
            default: begin
              if (M68K_RW) w_cpu_datain_next = OPEN_BUS;
              w_state_next = ST_ACK;
            end
          endcase
        end
      end

      ST_MEM_WAIT: begin
        // The request stays up even if nAS drops: the memory side is never
        // asked to abandon an access, only to finish it.
        if (MEM_ACK) begin
          if (!r_mem_we) w_cpu_datain_next = MEM_RDATA;
          w_mem_req_next = 1'b0;
          w_state_next   = nAS ? ST_IDLE : ST_ACK;
        end else if (r_cnt >= TO_CNT) begin
          w_timeout_err_next = 1'b1;
          if (!r_mem_we) w_cpu_datain_next = OPEN_BUS;
          w_mem_req_next = 1'b0;
          w_state_next   = nAS ? ST_IDLE : ST_ACK;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      ST_IO_WAIT: begin
        if (r_cnt == '0) begin
          if (!r_mem_we) w_cpu_datain_next = IO_RDATA;
          w_io_sel_next = 1'b0;
          w_state_next  = nAS ? ST_IDLE : ST_ACK;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end

      ST_ACK: begin
        if (nAS) w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase

    // nDTACK is simply "the sequencer is in ACK", registered alongside it.
    w_dtack_n_next = (w_state_next != ST_ACK);
  end

  assign nDTACK      = r_dtack_n;
  assign CPU_DATAIN  = r_cpu_datain;
  assign MEM_REQ     = r_mem_req;
  assign MEM_ADDR    = r_mem_addr;
  assign MEM_WE      = r_mem_we;
  assign MEM_BE      = r_mem_be;
  assign MEM_WDATA   = r_mem_wdata;
  assign IO_SEL      = r_io_sel;
  assign TIMEOUT_ERR = r_timeout_err;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb_m68k_bus_ctrl
// Directed bench for m68k_bus_ctrl. Each CPU access that should complete
// pushes its expected read data and acknowledge edge into a scoreboard; a
// monitor pops and compares whenever nDTACK falls.
module tb_m68k_bus_ctrl;

  logic        clk = 1'b0;
  logic        nRESET;
  logic [23:1] M68K_ADDR;
  logic        nAS, nUDS, nLDS, M68K_RW;
  logic [15:0] M68K_DATAOUT;
  logic        nDTACK;
  logic [15:0] CPU_DATAIN;
  logic        MEM_REQ;
  logic [22:0] MEM_ADDR;
  logic        MEM_WE;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic        IO_SEL;
  logic [15:0] IO_RDATA;
  logic        TIMEOUT_ERR;

  m68k_bus_ctrl #(.IO_WAIT(1), .TIMEOUT(255)) dut (
    .CLK_68KCLK  (clk),
    .nRESET      (nRESET),
    .M68K_ADDR   (M68K_ADDR),
    .nAS         (nAS),
    .nUDS        (nUDS),
    .nLDS        (nLDS),
    .M68K_RW     (M68K_RW),
    .M68K_DATAOUT(M68K_DATAOUT),
    .nDTACK      (nDTACK),
    .CPU_DATAIN  (CPU_DATAIN),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WE      (MEM_WE),
    .MEM_BE      (MEM_BE),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_ACK     (MEM_ACK),
    .MEM_RDATA   (MEM_RDATA),
    .IO_SEL      (IO_SEL),
    .IO_RDATA    (IO_RDATA),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge when read at a negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every falling nDTACK is one completed CPU access.
  logic prev_dtack = 1'b1;
  always @(negedge clk) begin
    if (prev_dtack === 1'b1 && nDTACK === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dtack: got nDTACK=0 at cycle %0d expected no acknowledge", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("ack  cycle=%0d data=%04h (expect data=%04h edge=%0d)", cyc, CPU_DATAIN, mon_e.data, mon_e.edge_n);
        check("dtack_data", CPU_DATAIN, mon_e.data);
        check("dtack_edge", cyc, mon_e.edge_n);
      end
    end
    prev_dtack <= nDTACK;
  end

  task automatic start(input logic [23:0] baddr, input logic rw, input logic u_n,
                       input logic l_n, input logic [15:0] wd, output int n);
    @(negedge clk);
    M68K_ADDR    = baddr[23:1];
    M68K_RW      = rw;
    nUDS         = u_n;
    nLDS         = l_n;
    M68K_DATAOUT = wd;
    nAS          = 1'b0;
    n            = cyc + 1;
  endtask

  task automatic release_bus(input string name);
    @(negedge clk);
    nAS  = 1'b1;
    nUDS = 1'b1;
    nLDS = 1'b1;
    @(negedge clk);
    check(name, nDTACK, 1'b1);
  endtask

  initial begin
    int n;
    int pulses;
    int pcyc;

    nRESET = 1'b0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; M68K_RW = 1'b1;
    M68K_ADDR = '0; M68K_DATAOUT = '0; MEM_ACK = 1'b0; MEM_RDATA = '0;
    IO_RDATA = 16'h5555;
    repeat (2) @(negedge clk);
    check("rst_dtack",   nDTACK, 1'b1);
    check("rst_req",     MEM_REQ, 1'b0);
    check("rst_datain",  CPU_DATAIN, 16'hFFFF);
    check("rst_be",      MEM_BE, 2'b00);
    check("rst_addr",    MEM_ADDR, 23'h0);
    check("rst_io_sel",  IO_SEL, 1'b0);
    check("rst_tmo",     TIMEOUT_ERR, 1'b0);
    nRESET = 1'b1;
    repeat (2) @(negedge clk);

    // 1) memory read 0x000100, ack 3 cycles after MEM_REQ
    start(24'h000100, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    sb.push_back('{16'h1234, n + 3});
    $display("txn  mem read 0x000100 start edge=%0d", n);
    @(negedge clk);
    check("rd_req_up", MEM_REQ, 1'b1);
    check("rd_we", MEM_WE, 1'b0);
    @(negedge clk);
    @(negedge clk);
    MEM_ACK = 1'b1; MEM_RDATA = 16'h1234;
    @(negedge clk);
    MEM_ACK = 1'b0;
    check("rd_req_down", MEM_REQ, 1'b0);
    release_bus("rd_release");

    // 2) upper-byte write 0x10FFFE, data AB00; CPU_DATAIN must keep 1234
    start(24'h10FFFE, 1'b0, 1'b0, 1'b1, 16'hAB00, n);
    sb.push_back('{16'h1234, n + 1});
    $display("txn  mem write 0x10FFFE start edge=%0d", n);
    @(negedge clk);
    check("wr_req",   MEM_REQ, 1'b1);
    check("wr_we",    MEM_WE, 1'b1);
    check("wr_be",    MEM_BE, 2'b10);
    check("wr_wdata", MEM_WDATA, 16'hAB00);
    check("wr_addr",  MEM_ADDR, 23'h087FFF);
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD;
    @(negedge clk);
    MEM_ACK = 1'b0;
    release_bus("wr_release");

    // 3) unmapped read 0xF00000: immediate open-bus acknowledge
    start(24'hF00000, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    sb.push_back('{16'hFFFF, n});
    $display("txn  unmapped read 0xF00000 start edge=%0d", n);
    @(negedge clk);
    check("um_req",    MEM_REQ, 1'b0);
    check("um_io_sel", IO_SEL, 1'b0);
    release_bus("um_release");

    // 4) I/O read 0x3C0000 with one wait state
    start(24'h3C0000, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    sb.push_back('{16'h5555, n + 2});
    $display("txn  io read 0x3C0000 start edge=%0d", n);
    @(negedge clk);
    check("io_sel_1", IO_SEL, 1'b1);
    check("io_req",   MEM_REQ, 1'b0);
    @(negedge clk);
    check("io_sel_2", IO_SEL, 1'b1);
    check("io_dtack_early", nDTACK, 1'b1);
    @(negedge clk);
    check("io_sel_off", IO_SEL, 1'b0);
    release_bus("io_release");

    // 5) memory read 0x200000 with no ack: timeout at N+255
    start(24'h200000, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    sb.push_back('{16'hFFFF, n + 255});
    $display("txn  mem read 0x200000 (timeout) start edge=%0d", n);
    pulses = 0;
    pcyc   = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (TIMEOUT_ERR === 1'b1) begin
        pulses++;
        pcyc = cyc;
      end
      if (nDTACK === 1'b0) break;
    end
    check("tmo_dtack_seen", nDTACK, 1'b0);
    check("tmo_pulses", pulses, 1);
    check("tmo_pulse_edge", pcyc, n + 255);
    @(negedge clk);
    check("tmo_pulse_end", TIMEOUT_ERR, 1'b0);
    MEM_ACK = 1'b1; MEM_RDATA = 16'h9999;
    @(negedge clk);
    MEM_ACK = 1'b0;
    check("tmo_late_ack_data", CPU_DATAIN, 16'hFFFF);
    check("tmo_late_ack_dtack", nDTACK, 1'b0);
    release_bus("tmo_release");

    // 6) aborted memory read: nAS rises while waiting, no acknowledge
    start(24'h000300, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    $display("txn  mem read 0x000300 (aborted) start edge=%0d", n);
    @(negedge clk);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    @(negedge clk);
    check("ab_req_held", MEM_REQ, 1'b1);
    @(negedge clk);
    MEM_ACK = 1'b1; MEM_RDATA = 16'h7777;
    @(negedge clk);
    MEM_ACK = 1'b0;
    check("ab_req_down", MEM_REQ, 1'b0);
    check("ab_dtack", nDTACK, 1'b1);
    repeat (2) @(negedge clk);
    check("ab_dtack_idle", nDTACK, 1'b1);

    // 7) reset during MEM_WAIT, then a clean access from 0xC00000
    start(24'h000200, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    $display("txn  mem read 0x000200 (reset mid-access) start edge=%0d", n);
    @(negedge clk);
    check("rs_req_up", MEM_REQ, 1'b1);
    #2 nRESET = 1'b0;
    #1;
    check("rs_req_async", MEM_REQ, 1'b0);
    check("rs_dtack_async", nDTACK, 1'b1);
    check("rs_datain_async", CPU_DATAIN, 16'hFFFF);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);
    start(24'hC00000, 1'b1, 1'b0, 1'b0, 16'h0000, n);
    sb.push_back('{16'h0F0F, n + 1});
    $display("txn  mem read 0xC00000 start edge=%0d", n);
    @(negedge clk);
    check("post_rs_req",  MEM_REQ, 1'b1);
    check("post_rs_addr", MEM_ADDR, 23'h600000);
    MEM_ACK = 1'b1; MEM_RDATA = 16'h0F0F;
    @(negedge clk);
    MEM_ACK = 1'b0;
    release_bus("post_rs_release");

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
